// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO.
package fifo_pkg;

    typedef enum logic {
        FIFO_MODE_STD  = 1'b0,
        FIFO_MODE_FWFT = 1'b1
    } fifo_mode_e;

    // Increment a pointer, wrapping to zero at depth; depth need not be a power of two.
    function automatic logic [31:0] ptr_wrap(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read, contents not reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 31,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read, level flags
// decoded from the registered count, and sticky overflow/underflow.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH          = 16,
    parameter int FIFO_DEPTH          = 31,
    parameter int FWFT                = 0,
    parameter int ALMOST_FULL_THRESH  = FIFO_DEPTH - 1,
    parameter int ALMOST_EMPTY_THRESH = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           clr,
    input  logic                           wr_en,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           full,
    output logic                           almost_full,
    input  logic                           rd_en,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           rd_valid,
    output logic                           empty,
    output logic                           almost_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0] AF_T  = ALMOST_FULL_THRESH;
    localparam logic [31:0] AE_T  = ALMOST_EMPTY_THRESH;
    localparam logic [31:0] DEPTH_32 = FIFO_DEPTH;
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_MODE_FWFT : FIFO_MODE_STD;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] mem_rd;
    logic                  wr_acc;
    logic                  rd_acc;

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (32'(count) >= AF_T);
    assign almost_empty = (32'(count) <= AE_T);

    assign wr_acc = wr_en & ~full  & ~clr;
    assign rd_acc = rd_en & ~empty & ~clr;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= PTR_W'(ptr_wrap(32'(wr_ptr), DEPTH_32));
            end
            if (rd_acc) begin
                rd_ptr <= PTR_W'(ptr_wrap(32'(rd_ptr), DEPTH_32));
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (MODE == FIFO_MODE_FWFT) begin : g_fwft
            // Head word is shown directly; forced to zero while empty so reset reads 0.
            assign rd_data  = empty ? '0 : mem_rd;
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= mem_rd;
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a standard-mode and an FWFT-mode instance at depth 5.
module tb_sync_fifo;

    localparam int DW = 16;
    localparam int DEPTH = 5;
    localparam int CW = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset_n;
    logic clr;

    logic          wr_en, rd_en;
    logic [DW-1:0] wr_data;
    logic          full, almost_full, empty, almost_empty, rd_valid, overflow, underflow;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] count;

    logic          f_wr_en, f_rd_en;
    logic [DW-1:0] f_wr_data;
    logic          f_full, f_almost_full, f_empty, f_almost_empty, f_rd_valid, f_overflow, f_underflow;
    logic [DW-1:0] f_rd_data;
    logic [CW-1:0] f_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0),
        .ALMOST_FULL_THRESH(4), .ALMOST_EMPTY_THRESH(1)
    ) u_std (
        .clk(clk), .reset_n(reset_n), .clr(clr),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1),
        .ALMOST_FULL_THRESH(4), .ALMOST_EMPTY_THRESH(1)
    ) u_fwft (
        .clk(clk), .reset_n(reset_n), .clr(clr),
        .wr_en(f_wr_en), .wr_data(f_wr_data), .full(f_full), .almost_full(f_almost_full),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty),
        .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " count"},        32'(count), 0);
        chk({tag, " empty"},        32'(empty), 1);
        chk({tag, " full"},         32'(full), 0);
        chk({tag, " almost_empty"}, 32'(almost_empty), 1);
        chk({tag, " almost_full"},  32'(almost_full), 0);
        chk({tag, " rd_data"},      32'(rd_data), 0);
        chk({tag, " rd_valid"},     32'(rd_valid), 0);
        chk({tag, " overflow"},     32'(overflow), 0);
        chk({tag, " underflow"},    32'(underflow), 0);
        chk({tag, " f_rd_data"},    32'(f_rd_data), 0);
        chk({tag, " f_rd_valid"},   32'(f_rd_valid), 0);
        chk({tag, " f_empty"},      32'(f_empty), 1);
    endtask

    initial begin
        reset_n = 1'b0; clr = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;

        #3;
        chk_reset_values("por");
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Fill to full, overflow attempt, drain in order.
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; wr_data = 16'(i);
            tick();
            if (i == 2) chk("ae_at_2", 32'(almost_empty), 0);
            if (i == 3) chk("af_at_3", 32'(almost_full), 0);
            if (i == 4) begin
                chk("af_at_4",   32'(almost_full), 1);
                chk("full_at_4", 32'(full), 0);
            end
        end
        chk("full_at_5",  32'(full), 1);
        chk("count_at_5", 32'(count), 5);
        wr_data = 16'hDEAD;
        tick();
        wr_en = 1'b0;
        chk("ovf_set",    32'(overflow), 1);
        chk("count_ovf",  32'(count), 5);
        for (int i = 1; i <= 5; i++) begin
            rd_en = 1'b1;
            tick();
            chk($sformatf("drain_data_%0d", i), 32'(rd_data), 32'(i));
            chk($sformatf("drain_vld_%0d", i), 32'(rd_valid), 1);
            if (i == 4) chk("ae_at_1", 32'(almost_empty), 1);
        end
        rd_en = 1'b0;
        tick();
        chk("drain_empty",  32'(empty), 1);
        chk("vld_pulse",    32'(rd_valid), 0);
        chk("rd_data_hold", 32'(rd_data), 5);
        chk("ovf_sticky",   32'(overflow), 1);
        chk("unf_clean",    32'(underflow), 0);

        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);

        // Streaming write+read across two pointer wraps.
        for (int i = 0; i < 12; i++) begin
            wr_en = 1'b1; wr_data = 16'h0100 + 16'(i);
            rd_en = (i != 0);
            tick();
            if (i != 0) chk($sformatf("stream_%0d", i), 32'(rd_data), 32'h0100 + 32'(i - 1));
            chk($sformatf("stream_cnt_%0d", i), 32'(count), 1);
        end
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("stream_last",  32'(rd_data), 32'h010B);
        chk("stream_empty", 32'(empty), 1);

        // Simultaneous read/write at full and at count 2.
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 16'h0200 + 16'(i);
            tick();
        end
        wr_data = 16'h0BAD; rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("fullrw_count", 32'(count), 4);
        chk("fullrw_ovf",   32'(overflow), 1);
        chk("fullrw_data",  32'(rd_data), 32'h0200);
        tick();
        chk("rd_0201", 32'(rd_data), 32'h0201);
        tick();
        chk("rd_0202", 32'(rd_data), 32'h0202);
        chk("cnt_2",   32'(count), 2);
        wr_en = 1'b1; wr_data = 16'h0205;
        tick();
        wr_en = 1'b0;
        chk("rw2_count", 32'(count), 2);
        chk("rw2_data",  32'(rd_data), 32'h0203);
        tick();
        chk("rd_0204", 32'(rd_data), 32'h0204);
        tick();
        rd_en = 1'b0;
        chk("rd_0205",    32'(rd_data), 32'h0205);
        chk("rw_empty",   32'(empty), 1);

        // Flush with a concurrent write at count 2.
        clr = 1'b1; tick(); clr = 1'b0;
        wr_en = 1'b1; wr_data = 16'h0301; tick();
        wr_data = 16'h0302; tick();
        clr = 1'b1; wr_data = 16'h0303;
        tick();
        clr = 1'b0; wr_en = 1'b0;
        chk("clr_count", 32'(count), 0);
        chk("clr_empty", 32'(empty), 1);
        chk("clr_ovf2",  32'(overflow), 0);
        chk("clr_unf",   32'(underflow), 0);
        wr_en = 1'b1; wr_data = 16'h0304; tick(); wr_en = 1'b0;
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("post_clr_data", 32'(rd_data), 32'h0304);

        // Read while empty with a concurrent write.
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 16'h0305;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        chk("unf_set",     32'(underflow), 1);
        chk("unf_count",   32'(count), 1);
        chk("unf_vld",     32'(rd_valid), 0);
        chk("unf_hold",    32'(rd_data), 32'h0304);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("rd_0305", 32'(rd_data), 32'h0305);

        // Asynchronous reset mid-cycle with count 3.
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 16'h0400 + 16'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("pre_rst_count", 32'(count), 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_values("midrst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("post_rst_unf",   32'(underflow), 1);
        chk("post_rst_vld",   32'(rd_valid), 0);
        chk("post_rst_count", 32'(count), 0);

        // FWFT instance.
        chk("f_empty_init", 32'(f_rd_valid), 0);
        f_wr_en = 1'b1; f_wr_data = 16'hA5A5;
        tick();
        f_wr_en = 1'b0;
        chk("f_fall_data", 32'(f_rd_data), 32'hA5A5);
        chk("f_fall_vld",  32'(f_rd_valid), 1);
        f_wr_en = 1'b1; f_wr_data = 16'h5A5A;
        tick();
        f_wr_en = 1'b0;
        chk("f_head_hold", 32'(f_rd_data), 32'hA5A5);
        chk("f_count_2",   32'(f_count), 2);
        f_rd_en = 1'b1;
        tick();
        chk("f_pop1_data", 32'(f_rd_data), 32'h5A5A);
        chk("f_pop1_vld",  32'(f_rd_valid), 1);
        tick();
        chk("f_pop2_vld",  32'(f_rd_valid), 0);
        chk("f_pop2_empty", 32'(f_empty), 1);
        chk("f_pop2_unf",  32'(f_underflow), 0);
        tick();
        f_rd_en = 1'b0;
        chk("f_unf_set",   32'(f_underflow), 1);
        chk("f_unf_count", 32'(f_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 16: data word width in bits; SHALL be >= 1.
REQ-002 Parameter FIFO_DEPTH, default 31: number of storage words; SHALL be >= 2 and SHALL NOT need to be a power of two.
REQ-003 Parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-004 Parameter ALMOST_FULL_THRESH, default FIFO_DEPTH-1: almost_full asserts at count >= this value.
REQ-005 Parameter ALMOST_EMPTY_THRESH, default 1: almost_empty asserts at count <= this value.
REQ-006 Ports (name  direction  width  meaning) SHALL be exactly:
  clk  in  1  single clock; all logic on rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  clr  in  1  synchronous flush.
  wr_en  in  1  write request.
  wr_data  in  DATA_WIDTH  write word.
  full  out  1  no free word.
  almost_full  out  1  count >= ALMOST_FULL_THRESH.
  rd_en  in  1  read request.
  rd_data  out  DATA_WIDTH  read word.
  rd_valid  out  1  rd_data valid (see REQ-013/014).
  empty  out  1  no stored word.
  almost_empty  out  1  count <= ALMOST_EMPTY_THRESH.
  count  out  $clog2(FIFO_DEPTH+1)  stored words.
  overflow  out  1  sticky: write attempted while full.
  underflow  out  1  sticky: read attempted while empty.
REQ-007 The block SHALL use one clock and an asynchronous active-low reset, as stated in REQ-006.

Function
REQ-008 wr_acc = wr_en & ~full & ~clr; rd_acc = rd_en & ~empty & ~clr; full/empty SHALL be evaluated from the current-cycle registered count, never from same-cycle rd_en/wr_en.
REQ-009 wr_acc SHALL store wr_data at wr_ptr and advance wr_ptr; rd_acc SHALL advance rd_ptr.
REQ-010 Pointers SHALL wrap FIFO_DEPTH-1 -> 0 and be $clog2(FIFO_DEPTH) bits wide.
REQ-011 count SHALL update +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither; it SHALL never exceed FIFO_DEPTH or go below 0.
REQ-012 full = (count == FIFO_DEPTH), empty = (count == 0), almost flags per REQ-004/005; all registered or decoded from registered count, no input-to-output combinational path.
REQ-013 FWFT=0: rd_acc SHALL load rd_data with the head word one cycle later and pulse rd_valid high for exactly that cycle; rd_data SHALL hold its value otherwise.
REQ-014 FWFT=1: rd_data SHALL present the head word whenever empty=0, rd_valid = ~empty; rd_acc pops, next word visible the following cycle; a word written into an empty FIFO SHALL be visible the cycle after the write.
REQ-015 Write while full: word discarded, state unchanged, overflow set, even if rd_en is asserted the same cycle.
REQ-016 Read while empty: no state change, rd_valid stays low, underflow set, even if wr_en is asserted the same cycle (the write is still accepted).
REQ-017 clr=1: pointers, count, overflow, underflow, rd_valid SHALL be 0 next cycle; simultaneous wr_en/rd_en SHALL be ignored and flagged as neither overflow nor underflow; memory contents need not be cleared.
REQ-018 overflow/underflow SHALL clear only on reset or clr.

Reset
REQ-019 While reset_n=0, immediately and independently of clk: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full (0 >= ALMOST_FULL_THRESH), rd_data 0, rd_valid 0, overflow 0, underflow 0.
REQ-020 Reset mid-operation SHALL discard all stored words; the first cycle after release SHALL behave as an empty FIFO.

Structure
REQ-021 Package fifo_pkg SHALL hold the fifo_mode_e enum (FIFO_MODE_STD, FIFO_MODE_FWFT) and a ptr_wrap function (increment with wrap at depth).
REQ-022 Storage SHALL be in sub-module fifo_mem: FIFO_DEPTH x DATA_WIDTH array, synchronous write, asynchronous read, no reset on the array.

Verification (DATA_WIDTH=16, FIFO_DEPTH=5, ALMOST_FULL_THRESH=4, ALMOST_EMPTY_THRESH=1)
REQ-023 Write 0x0001..0x0005 -> almost_full after 4th write, full=1 and count=5 after 5th; write 0xDEAD -> ignored, overflow=1; 5 reads -> 0x0001..0x0005 in order, empty=1.
REQ-024 Interleave 12 writes/reads (0x0100..0x010B) -> output order preserved across both pointer wraps 4->0.
REQ-025 Count=5, rd_en+wr_en same cycle -> read accepted, write rejected, overflow=1, count=4; at count=2 both asserted -> both accepted, count stays 2.
REQ-026 FWFT=1: write 0xA5A5 into empty -> next cycle rd_data=0xA5A5, rd_valid=1 without rd_en; rd_en on empty -> underflow=1.
REQ-027 Count=3, reset_n low mid-cycle -> all outputs at REQ-019 values before next clk edge; after release a read sets underflow=1.
REQ-028 Count=2, clr with wr_en=1 -> next cycle count=0, empty=1, written word never read out.
